// File: rtl/vga_timing_pkg.sv
// Shared timing presets, RGB565 colour-bar constants and a counter-width helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package vga_timing_pkg;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BACK   = 48;
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FRONT  = 16;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BACK   = 33;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FRONT  = 10;
    localparam int VGA640_H_TOTAL  = VGA640_H_SYNC + VGA640_H_BACK + VGA640_H_ACTIVE + VGA640_H_FRONT;
    localparam int VGA640_V_TOTAL  = VGA640_V_SYNC + VGA640_V_BACK + VGA640_V_ACTIVE + VGA640_V_FRONT;

    // 800x600@60, 40 MHz pixel clock
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BACK   = 88;
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FRONT  = 40;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BACK   = 23;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FRONT  = 1;

    // RGB565 colour-bar palette, left to right
    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;

    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    function automatic logic [15:0] bar_colour(input bar_e idx);
        case (idx)
            BAR_WHITE:   return RGB565_WHITE;
            BAR_YELLOW:  return RGB565_YELLOW;
            BAR_CYAN:    return RGB565_CYAN;
            BAR_GREEN:   return RGB565_GREEN;
            BAR_MAGENTA: return RGB565_MAGENTA;
            BAR_RED:     return RGB565_RED;
            BAR_BLUE:    return RGB565_BLUE;
            default:     return RGB565_BLACK;
        endcase
    endfunction

    // Counter width wide enough for the longer of the two raster axes
    function automatic int calc_cw(input int h_total, input int v_total);
        return $clog2((h_total > v_total) ? h_total : v_total);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus: pixel request/coordinates to the image source, sync and rgb to the DAC.
// Latency: n/a (wires only); pix_data is expected one clock after data_req.
// Backpressure: none; the source must answer every request in exactly one clock.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CW     = calc_cw(VGA640_H_TOTAL, VGA640_V_TOTAL)
);
    logic [DATA_W-1:0] pix_data;
    logic              data_req;
    logic [CW-1:0]     pix_x;
    logic [CW-1:0]     pix_y;
    logic              hsync;
    logic              vsync;
    logic              rgb_valid;
    logic [DATA_W-1:0] rgb;
    logic              frame_start;

    // Timing generator side
    modport master (
        input  pix_data,
        output data_req, pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start
    );

    // Image source / display side
    modport slave (
        output pix_data,
        input  data_req, pix_x, pix_y, hsync, vsync, rgb_valid, rgb, frame_start
    );
endinterface

// File: rtl/vga_tpg.sv
// Eight-bar RGB565 colour pattern indexed by the requested column (only built with VGA_TPG_EN).
// Latency: 1 clock from pix_x to colour, lining up with the rgb_valid cycle.
// Backpressure: none; follows the raster unconditionally.
`ifdef VGA_TPG_EN
module vga_tpg
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] pix_x,
    output logic [15:0]   colour
);
    localparam int BAR_W = H_ACTIVE / 8;

    logic [CW-1:0] px_q;
    logic [CW-1:0] px_d;
    int            bar_idx;

    // Next value of the delayed column
    always_comb begin
        px_d = pix_x;
    end

    // Delay the column by one clock so the colour lands on the returned-pixel slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            px_q <= '0;
        end else begin
            px_q <= px_d;
        end
    end

    // Bar lookup; columns past the eighth bar (remainder) stay on the last bar
    always_comb begin
        bar_idx = int'(px_q) / BAR_W;
        if (bar_idx > 7) begin
            bar_idx = 7;
        end
        colour = bar_colour(bar_e'(bar_idx[2:0]));
    end
endmodule
`endif

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing: H/V counters, sync decode, one-cycle-ahead pixel request, rgb gating.
// Latency: data_req/pix_x/pix_y lead rgb_valid by 1 clock; rgb is pix_data gated combinationally.
// Backpressure: none; the source must return pix_data one clock after each data_req. VGA_TPG_EN adds tpg_sel and colour bars.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BACK   = VGA640_H_BACK,
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FRONT  = VGA640_H_FRONT,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BACK   = VGA640_V_BACK,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FRONT  = VGA640_V_FRONT,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef VGA_TPG_EN
    input  logic tpg_sel,
`endif
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HA_S    = H_SYNC + H_BACK;
    localparam int HA_E    = HA_S + H_ACTIVE - 1;
    localparam int VA_S    = V_SYNC + V_BACK;
    localparam int VA_E    = VA_S + V_ACTIVE - 1;
    localparam int CW      = calc_cw(H_TOTAL, V_TOTAL);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
    localparam cnt_t REQ_S   = cnt_t'(HA_S - 1);
    localparam cnt_t REQ_E   = cnt_t'(HA_E - 1);
    localparam cnt_t VACT_S  = cnt_t'(VA_S);
    localparam cnt_t VACT_E  = cnt_t'(VA_E);
    localparam cnt_t HSYNC_W = cnt_t'(H_SYNC);
    localparam cnt_t VSYNC_W = cnt_t'(V_SYNC);

    // Parameter sanity: the request lead needs at least one blanking clock before active video
    generate
        if (HA_S < 1) begin : g_bad_lead
            $error("vga_timing_gen: H_SYNC + H_BACK must be >= 1");
        end
        if (H_ACTIVE < 8) begin : g_bad_h_active
            $error("vga_timing_gen: H_ACTIVE must be >= 8");
        end
        if (V_ACTIVE < 1) begin : g_bad_v_active
            $error("vga_timing_gen: V_ACTIVE must be >= 1");
        end
`ifdef VGA_TPG_EN
        if (DATA_W != 16) begin : g_bad_tpg_width
            $error("vga_timing_gen: colour bars are RGB565, DATA_W must be 16");
        end
`endif
    endgenerate

    cnt_t              cnt_h_q, cnt_h_d;
    cnt_t              cnt_v_q, cnt_v_d;
    cnt_t              pix_x_q, pix_x_d;
    cnt_t              pix_y_q, pix_y_d;
    logic              data_req_q, data_req_d;
    logic              rgb_valid_q, rgb_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              h_last;
    logic              v_last;
    logic              v_act;
    logic [DATA_W-1:0] rgb_sel;

    // Next raster position and the strobes that belong to it; outputs are decoded
    // from the next counters so the registered strobes line up with cnt_h_q/cnt_v_q
    always_comb begin
        h_last  = (cnt_h_q == H_LAST);
        v_last  = (cnt_v_q == V_LAST);
        cnt_h_d = h_last ? '0 : cnt_h_q + 1'b1;
        cnt_v_d = cnt_v_q;
        if (h_last) begin
            cnt_v_d = v_last ? '0 : cnt_v_q + 1'b1;
        end
        v_act         = (cnt_v_d >= VACT_S) && (cnt_v_d <= VACT_E);
        // Request window ends at HA_E-1, so the lead never spills into the next line
        data_req_d    = v_act && (cnt_h_d >= REQ_S) && (cnt_h_d <= REQ_E);
        pix_x_d       = data_req_d ? cnt_h_d - REQ_S  : '0;
        pix_y_d       = data_req_d ? cnt_v_d - VACT_S : '0;
        rgb_valid_d   = data_req_q;
        frame_start_d = (cnt_h_d == '0) && (cnt_v_d == '0);
    end

    // Raster state; reset restarts cleanly at (0,0) with all strobes low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_h_q       <= '0;
            cnt_v_q       <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            data_req_q    <= 1'b0;
            rgb_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            data_req_q    <= data_req_d;
            rgb_valid_q   <= rgb_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TPG_EN
    logic [15:0] tpg_colour;

    vga_tpg #(
        .H_ACTIVE (H_ACTIVE),
        .CW       (CW)
    ) u_tpg (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_x  (pix_x_q),
        .colour (tpg_colour)
    );
`endif

    // Pixel gating: blank outside active video, otherwise the returned pixel (or the bars)
    always_comb begin
        rgb_sel = '0;
        if (rgb_valid_q) begin
`ifdef VGA_TPG_EN
            rgb_sel = tpg_sel ? DATA_W'(tpg_colour) : bus.pix_data;
`else
            rgb_sel = bus.pix_data;
`endif
        end
    end

    assign bus.hsync       = (cnt_h_q < HSYNC_W) ? HS_POL : ~HS_POL;
    assign bus.vsync       = (cnt_v_q < VSYNC_W) ? VS_POL : ~VS_POL;
    assign bus.data_req    = data_req_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.rgb_valid   = rgb_valid_q;
    assign bus.rgb         = rgb_sel;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: 640x480 default instance plus a tiny 16x5 raster instance on one clock.
// Latency: checks sampled on the falling edge; the source answers each request one clock later.
// Backpressure: n/a.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
`ifdef VGA_TPG_EN
    logic tpg_sel;
    logic tpg_sel_b;
`endif

    always #5 clk = ~clk;

    vga_timing_gen_if #(.DATA_W(16), .CW(10)) bus_a ();
    vga_timing_gen_if #(.DATA_W(16), .CW(4))  bus_b ();

    vga_timing_gen u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef VGA_TPG_EN
        .tpg_sel (tpg_sel),
`endif
        .bus     (bus_a)
    );

    vga_timing_gen #(
        .H_SYNC (4), .H_BACK (2), .H_ACTIVE (8), .H_FRONT (2),
        .V_SYNC (1), .V_BACK (1), .V_ACTIVE (2), .V_FRONT (1),
        .HS_POL (1'b0)
    ) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef VGA_TPG_EN
        .tpg_sel (tpg_sel_b),
`endif
        .bus     (bus_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Image source: returns the requested column as the pixel, one clock after the request
    initial begin
        logic [15:0] nxt_a;
        logic [15:0] nxt_b;
        bus_a.pix_data = '0;
        bus_b.pix_data = '0;
        forever begin
            @(negedge clk);
            nxt_a = bus_a.data_req ? 16'(bus_a.pix_x) : 16'h0;
            nxt_b = bus_b.data_req ? 16'(bus_b.pix_x) : 16'h0;
            @(posedge clk);
            #1;
            bus_a.pix_data = nxt_a;
            bus_b.pix_data = nxt_b;
        end
    end

    int h;
    int blank_bad;
    int vcnt;
    int rcnt;
    int fs_cnt_b;
    int req_cnt_b;
    logic exp_req;
    logic exp_vld;

    initial begin
        rst_n = 1'b0;
`ifdef VGA_TPG_EN
        tpg_sel   = 1'b0;
        tpg_sel_b = 1'b0;
`endif
        blank_bad = 0;
        vcnt = 0;
        rcnt = 0;
        fs_cnt_b = 0;
        req_cnt_b = 0;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst_data_req",    bus_a.data_req, 0);
        chk("rst_rgb_valid",   bus_a.rgb_valid, 0);
        chk("rst_pix_x",       bus_a.pix_x, 0);
        chk("rst_pix_y",       bus_a.pix_y, 0);
        chk("rst_frame_start", bus_a.frame_start, 0);
        chk("rst_rgb",         bus_a.rgb, 0);
        chk("rst_hsync",       bus_a.hsync, 1);
        chk("rst_vsync",       bus_a.vsync, 1);
        chk("rst_hsync_b",     bus_b.hsync, 0);
        chk("rst_vsync_b",     bus_b.vsync, 1);

        rst_n = 1'b1;
        // Index i: raster position i clocks after release (cnt_h = i % H_TOTAL)
        for (int i = 0; i <= 30000; i++) begin
            if (i > 0) @(negedge clk);

            // ---- default 640x480 instance ----
            if (i == 0) begin
                chk("a0_hsync", bus_a.hsync, 1);
                chk("a0_vsync", bus_a.vsync, 1);
                chk("a0_frame_start", bus_a.frame_start, 0);
                chk("a0_data_req", bus_a.data_req, 0);
            end
            if (i == 95)   chk("hsync_h95", bus_a.hsync, 1);
            if (i == 96)   chk("hsync_h96", bus_a.hsync, 0);
            if (i == 799)  chk("hsync_h799", bus_a.hsync, 0);
            if (i == 799)  chk("vsync_l0", bus_a.vsync, 1);
            if (i == 800)  chk("hsync_period", bus_a.hsync, 1);
            if (i == 1599) chk("vsync_l1", bus_a.vsync, 1);
            if (i == 1600) chk("vsync_l2", bus_a.vsync, 0);
            if (i > 0 && i < 28000) begin
                if (bus_a.data_req || bus_a.rgb_valid || bus_a.rgb != 0 || bus_a.frame_start)
                    blank_bad++;
            end
            if (i == 28000) chk("blank_lines_0_34", blank_bad, 0);

            // Line 35: first active line, checked every clock
            if (i >= 28000 && i < 28800) begin
                h = i - 28000;
                exp_req = (h >= 143) && (h <= 782);
                exp_vld = (h >= 144) && (h <= 783);
                chk("l35_data_req", bus_a.data_req, exp_req);
                chk("l35_pix_x", bus_a.pix_x, exp_req ? h - 143 : 0);
                chk("l35_pix_y", bus_a.pix_y, 0);
                chk("l35_rgb_valid", bus_a.rgb_valid, exp_vld);
                chk("l35_rgb", bus_a.rgb, exp_vld ? h - 144 : 0);
                vcnt += int'(bus_a.rgb_valid);
                rcnt += int'(bus_a.data_req);
            end
            if (i == 28800) begin
                chk("l35_valid_cnt", vcnt, 640);
                chk("l35_req_cnt", rcnt, 640);
                chk("l36_vsync", bus_a.vsync, 0);
`ifdef VGA_TPG_EN
                tpg_sel = 1'b1;
`endif
            end
            if (i == 28943) begin
                chk("l36_first_req", bus_a.data_req, 1);
                chk("l36_first_px", bus_a.pix_x, 0);
                chk("l36_pix_y", bus_a.pix_y, 1);
            end
`ifdef VGA_TPG_EN
            if (i == 28944) chk("tpg_px0", bus_a.rgb, 16'hFFFF);
            if (i == 29024) chk("tpg_px80", bus_a.rgb, 16'hFFE0);
            if (i == 29104) chk("tpg_px160", bus_a.rgb, 16'h07FF);
            if (i == 29503) chk("tpg_px559", bus_a.rgb, 16'h001F);
            if (i == 29583) chk("tpg_px639", bus_a.rgb, 16'h0000);
            if (i == 29599) tpg_sel = 1'b0;
`else
            if (i == 29583) chk("l36_last_rgb", bus_a.rgb, 639);
`endif
            if (i == 29584) chk("l36_after_rgb", bus_a.rgb, 0);
            if (i == 29745) chk("l37_rgb_px1", bus_a.rgb, 1);
            if (i == 30000) begin
                chk("l37_mid_req", bus_a.data_req, 1);
                chk("l37_mid_px", bus_a.pix_x, 257);
                chk("l37_mid_py", bus_a.pix_y, 2);
            end

            // ---- 16x5 override instance ----
            if (i == 0)  chk("b_hsync_h0", bus_b.hsync, 0);
            if (i == 3)  chk("b_hsync_h3", bus_b.hsync, 0);
            if (i == 4)  chk("b_hsync_h4", bus_b.hsync, 1);
            if (i == 16) chk("b_hsync_period", bus_b.hsync, 0);
            if (i == 15) chk("b_vsync_l0", bus_b.vsync, 1);
            if (i == 16) chk("b_vsync_l1", bus_b.vsync, 0);
            if (i == 36) chk("b_req_h4", bus_b.data_req, 0);
            if (i == 37) begin
                chk("b_req_h5", bus_b.data_req, 1);
                chk("b_px_h5", bus_b.pix_x, 0);
                chk("b_py_h5", bus_b.pix_y, 0);
            end
            if (i == 44) begin
                chk("b_req_h12", bus_b.data_req, 1);
                chk("b_px_h12", bus_b.pix_x, 7);
            end
            if (i == 45) begin
                chk("b_req_h13", bus_b.data_req, 0);
                chk("b_vld_h13", bus_b.rgb_valid, 1);
                chk("b_rgb_h13", bus_b.rgb, 7);
            end
            if (i == 46) begin
                chk("b_vld_h14", bus_b.rgb_valid, 0);
                chk("b_rgb_h14", bus_b.rgb, 0);
            end
            if (i == 53) begin
                chk("b_l3_req", bus_b.data_req, 1);
                chk("b_l3_py", bus_b.pix_y, 1);
            end
            if (i < 80) req_cnt_b += int'(bus_b.data_req);
            if (i == 80) begin
                chk("b_req_per_frame", req_cnt_b, 16);
                chk("b_frame_start", bus_b.frame_start, 1);
                chk("b_vsync_wrap", bus_b.vsync, 1);
            end
            if (i == 81) chk("b_frame_start_1cyc", bus_b.frame_start, 0);
            if (i >= 1 && i <= 160) fs_cnt_b += int'(bus_b.frame_start);
            if (i == 160) chk("b_frame_start_cnt", fs_cnt_b, 2);
        end

        // Mid-frame reset at line 37, cnt_h 400, held for 3 clocks
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_data_req", bus_a.data_req, 0);
        chk("mrst_rgb", bus_a.rgb, 0);
        chk("mrst_pix_x", bus_a.pix_x, 0);
        chk("mrst_hsync", bus_a.hsync, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        blank_bad = 0;
        for (int j = 0; j <= 1700; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 0) begin
                chk("cold_data_req", bus_a.data_req, 0);
                chk("cold_rgb", bus_a.rgb, 0);
                chk("cold_rgb_valid", bus_a.rgb_valid, 0);
                chk("cold_hsync", bus_a.hsync, 1);
                chk("cold_vsync", bus_a.vsync, 1);
                chk("cold_frame_start", bus_a.frame_start, 0);
            end
            if (j == 95)   chk("cold_hsync_h95", bus_a.hsync, 1);
            if (j == 96)   chk("cold_hsync_h96", bus_a.hsync, 0);
            if (j == 800)  chk("cold_hsync_period", bus_a.hsync, 1);
            if (j == 1599) chk("cold_vsync_l1", bus_a.vsync, 1);
            if (j == 1600) chk("cold_vsync_l2", bus_a.vsync, 0);
            if (j > 0 && (bus_a.data_req || bus_a.rgb_valid || bus_a.rgb != 0))
                blank_bad++;
            if (j == 37)  chk("cold_b_req", bus_b.data_req, 1);
            if (j == 80)  chk("cold_b_frame_start", bus_b.frame_start, 1);
            if (j == 1700) chk("cold_blank", blank_bad, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
